// File: rtl/wide_add_sequencer_pkg.sv
// Shared types and constants for the sliced wide add/subtract engine.
package wide_add_sequencer_pkg;

    localparam int SLICE_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic bit width_ok(input int w);
        return (w >= SLICE_W) && ((w % SLICE_W) == 0);
    endfunction

endpackage

// File: rtl/wide_add_sequencer_carry_bypass.sv
// 32-bit carry-bypass adder: 4-bit ripple blocks whose carry skips the block
// when every bit propagates.
module carry_bypass_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    localparam int BLK  = 4;
    localparam int NBLK = 32 / BLK;

    logic [31:0]     prop;
    logic [NBLK-1:0] blk_prop;

    assign prop = a ^ b;

    genvar gi;
    generate
        for (gi = 0; gi < NBLK; gi++) begin : g_blk_prop
            assign blk_prop[gi] = &prop[gi*BLK +: BLK];
        end
    endgenerate

    always_comb begin : ripple
        logic blk_c;
        logic rip_c;
        sum   = '0;
        blk_c = cin;
        rip_c = cin;
        for (int bi = 0; bi < NBLK; bi++) begin
            rip_c = blk_c;
            for (int k = 0; k < BLK; k++) begin
                sum[bi*BLK+k] = prop[bi*BLK+k] ^ rip_c;
                rip_c = (a[bi*BLK+k] & b[bi*BLK+k]) | (prop[bi*BLK+k] & rip_c);
            end
            // A fully propagating block passes its carry-in straight through.
            blk_c = blk_prop[bi] ? blk_c : rip_c;
        end
        cout = blk_c;
    end

endmodule

// File: rtl/wide_add_sequencer.sv
// WIDTH-bit add/subtract performed as NSLICE passes through one 32-bit adder,
// LSB slice first, with valid/ready handshakes on both sides.
module wide_add_sequencer
    import wide_add_sequencer_pkg::*;
#(
    parameter int WIDTH = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    // An illegal WIDTH yields a negative slice count and fails elaboration.
    localparam bit WIDTH_OK = width_ok(WIDTH);
    localparam int NSLICE   = WIDTH_OK ? (WIDTH / SLICE_W) : -1;
    localparam int IDXW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int MSB      = WIDTH - 1;

    state_t             state_reg, state_next;
    logic [IDXW-1:0]    idx_reg;
    logic               carry_reg;
    logic [WIDTH-1:0]   a_reg, b_reg, sum_reg, sum_next;
    logic               cout_reg, ovf_reg, zero_reg;
    logic [SLICE_W-1:0] a_slices [NSLICE];
    logic [SLICE_W-1:0] b_slices [NSLICE];
    logic [SLICE_W-1:0] a_slice, b_slice, s_slice;
    logic               s_cout;
    logic               last_slice;

    genvar gi;
    generate
        for (gi = 0; gi < NSLICE; gi++) begin : g_slice
            assign a_slices[gi] = a_reg[gi*SLICE_W +: SLICE_W];
            assign b_slices[gi] = b_reg[gi*SLICE_W +: SLICE_W];
            // Only the slice being processed this cycle is replaced.
            assign sum_next[gi*SLICE_W +: SLICE_W] =
                (state_reg == RUN && idx_reg == IDXW'(gi)) ? s_slice
                                                           : sum_reg[gi*SLICE_W +: SLICE_W];
        end
    endgenerate

    assign a_slice    = a_slices[idx_reg];
    assign b_slice    = b_slices[idx_reg];
    assign last_slice = (idx_reg == IDXW'(NSLICE - 1));

    carry_bypass_32bit u_adder (
        .a    (a_slice),
        .b    (b_slice),
        .cin  (carry_reg),
        .sum  (s_slice),
        .cout (s_cout)
    );

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                if (last_slice) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            carry_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
            zero_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= in_a;
                        b_reg     <= in_b ^ {WIDTH{in_sub}};
                        carry_reg <= in_sub;
                        idx_reg   <= '0;
                        sum_reg   <= '0;
                        cout_reg  <= 1'b0;
                        ovf_reg   <= 1'b0;
                        zero_reg  <= 1'b0;
                    end
                end
                RUN: begin
                    sum_reg   <= sum_next;
                    carry_reg <= s_cout;
                    idx_reg   <= last_slice ? '0 : idx_reg + 1'b1;
                    if (last_slice) begin
                        cout_reg <= s_cout;
                        ovf_reg  <= (a_reg[MSB] == b_reg[MSB]) &&
                                    (s_slice[SLICE_W-1] != a_reg[MSB]);
                        zero_reg <= (sum_next == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_sum  = sum_reg;
    assign out_cout = cout_reg;
    assign out_ovf  = ovf_reg;
    assign out_zero = zero_reg;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Randomised and directed bench for wide_add_sequencer against a plain-arithmetic model.
module tb_wide_add_sequencer;

    localparam int W  = 128;
    localparam int NS = W / 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, in_sub;
    logic         out_valid, out_ready, out_cout, out_ovf, out_zero;
    logic [W-1:0] in_a, in_b, out_sum;

    always #5 clk = ~clk;

    wide_add_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero)
    );

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } res_t;

    res_t exp_q[$];
    int   passed = 0;
    int   total  = 0;
    int   cyc    = 0;
    int   acc_cyc = 0;
    bit   busy   = 1'b0;
    bit   seen_valid = 1'b0;

    task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h want %h", name, act, exp);
        else passed++;
    endtask

    // Result from integer arithmetic: unsigned for sum/carry, widened signed for overflow.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        res_t r;
        logic [W:0] u;
        logic signed [W+1:0] sa, sb, sr, smax, smin;
        u    = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
        sa   = signed'({{2{a[W-1]}}, a});
        sb   = signed'({{2{b[W-1]}}, b});
        sr   = sub ? (sa - sb) : (sa + sb);
        smax = signed'({3'b000, {(W-1){1'b1}}});
        smin = signed'({3'b111, {(W-1){1'b0}}});
        r.sum  = u[W-1:0];
        r.cout = sub ? (a >= b) : u[W];
        r.ovf  = (sr > smax) || (sr < smin);
        r.zero = (u[W-1:0] == '0);
        return r;
    endfunction

    always @(negedge clk) begin
        bit was_busy;
        cyc++;
        if (rst) begin
            exp_q.delete();
            busy       = 1'b0;
            seen_valid = 1'b0;
        end else begin
            was_busy = busy;
            chk("in_ready", in_ready, !busy);
            if (!busy) begin
                chk("out_valid_idle", out_valid, 1'b0);
            end else if (!seen_valid) begin
                if (out_valid) begin
                    chk("latency", cyc - acc_cyc, NS + 1);
                    seen_valid = 1'b1;
                end else if (cyc - acc_cyc > NS + 1) begin
                    chk("latency_timeout", cyc - acc_cyc, NS + 1);
                    seen_valid = 1'b1;
                end
            end else begin
                chk("out_valid_hold", out_valid, 1'b1);
            end
            if (out_valid && exp_q.size() > 0) begin
                chk("m_sum",  out_sum,  exp_q[0].sum);
                chk("m_cout", out_cout, exp_q[0].cout);
                chk("m_ovf",  out_ovf,  exp_q[0].ovf);
                chk("m_zero", out_zero, exp_q[0].zero);
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    busy       = 1'b0;
                    seen_valid = 1'b0;
                end
            end
            if (!was_busy && in_valid) begin
                exp_q.push_back(model(in_a, in_b, in_sub));
                busy       = 1'b1;
                seen_valid = 1'b0;
                acc_cyc    = cyc;
            end
        end
    end

    function automatic logic [W-1:0] rand_op();
        case ($urandom % 6)
            0: return '0;
            1: return '1;
            2: return {1'b0, {(W-1){1'b1}}};
            3: return {1'b1, {(W-1){1'b0}}};
            default: return {$urandom, $urandom, $urandom, $urandom};
        endcase
    endfunction

    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic [W-1:0] es, input logic ec,
                          input logic eo, input logic ez);
        int n;
        @(posedge clk) #1;
        in_a = a; in_b = b; in_sub = s; in_valid = 1'b1; out_ready = 1'b0;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        if (!in_ready) chk({name, "_accept"}, in_ready, 1'b1);
        @(posedge clk) #1;
        in_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        chk({name, "_valid"}, out_valid, 1'b1);
        chk({name, "_sum"},   out_sum,   es);
        chk({name, "_cout"},  out_cout,  ec);
        chk({name, "_ovf"},   out_ovf,   eo);
        chk({name, "_zero"},  out_zero,  ez);
        $display("op %s a=%h b=%h sub=%0d sum=%h cout=%0d ovf=%0d zero=%0d",
                 name, a, b, s, out_sum, out_cout, out_ovf, out_zero);
        @(posedge clk) #1 out_ready = 1'b1;
        @(posedge clk) #1 out_ready = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready",  in_ready,  1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_sum",       out_sum,   '0);
        chk("rst_cout",      out_cout,  1'b0);
        chk("rst_ovf",       out_ovf,   1'b0);
        chk("rst_zero",      out_zero,  1'b0);

        run_op("chain", 128'hFFFFFFFF, 128'h1, 1'b0, 128'h1_00000000, 1'b0, 1'b0, 1'b0);
        run_op("wrap", '1, 128'h1, 1'b0, '0, 1'b1, 1'b0, 1'b1);
        run_op("borrow", '0, 128'h1, 1'b1, '1, 1'b0, 1'b0, 1'b0);
        run_op("sub_eq", 128'h5, 128'h5, 1'b1, '0, 1'b1, 1'b0, 1'b1);
        run_op("sovf", {1'b0, {127{1'b1}}}, 128'h1, 1'b0, {1'b1, {127{1'b0}}}, 1'b0, 1'b1, 1'b0);

        // Backpressure: result held while a new bundle waits on in_valid.
        @(posedge clk) #1;
        in_a = 128'd10; in_b = 128'd20; in_sub = 1'b0; in_valid = 1'b1;
        @(posedge clk) #1 in_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        @(posedge clk) #1;
        in_a = 128'd100; in_b = 128'd23; in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("bp_in_ready",  in_ready,  1'b0);
            chk("bp_out_valid", out_valid, 1'b1);
            chk("bp_sum",       out_sum,   128'd30);
            $display("bp cycle %0d in_ready=%0d out_valid=%0d sum=%0d", i, in_ready, out_valid, out_sum);
            @(posedge clk) #1;
        end
        out_ready = 1'b1;
        @(posedge clk) #1 out_ready = 1'b0;
        @(negedge clk);
        chk("bp_idle_ready", in_ready, 1'b1);
        @(posedge clk) #1 in_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        chk("bp_second_sum", out_sum, 128'd123);
        @(posedge clk) #1 out_ready = 1'b1;
        @(posedge clk) #1 out_ready = 1'b0;

        // Reset after two slices of an operation.
        @(posedge clk) #1;
        in_a = '1; in_b = '1; in_sub = 1'b0; in_valid = 1'b1;
        @(posedge clk) #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk) #1 rst = 1'b1;
        @(posedge clk) #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", out_valid, 1'b0);
        chk("abort_in_ready",  in_ready,  1'b1);
        chk("abort_sum",       out_sum,   '0);
        run_op("after_abort", 128'd3, 128'd4, 1'b0, 128'd7, 1'b0, 1'b0, 1'b0);

        // Random traffic against the model.
        for (int i = 0; i < 800; i++) begin
            @(posedge clk) #1;
            in_valid  = ($urandom % 3) != 0;
            in_a      = rand_op();
            in_b      = rand_op();
            in_sub    = $urandom % 2;
            out_ready = $urandom % 2;
        end
        @(posedge clk) #1;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("drain_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
